// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant, per-master re-arm on strobe drop,
// and a watchdog that completes transactions the slave never acknowledges.
module wb_master_arbiter #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_STB,
    input  logic        m0_WE,
    input  logic [31:0] m0_ADDR,
    input  logic [31:0] m0_DAT_I,
    output logic [31:0] m0_DAT_O,
    output logic        m0_ACK,
    input  logic        m1_STB,
    input  logic        m1_WE,
    input  logic [31:0] m1_ADDR,
    input  logic [31:0] m1_DAT_I,
    output logic [31:0] m1_DAT_O,
    output logic        m1_ACK,
    output logic        bus_STB,
    output logic        bus_WE,
    output logic [31:0] bus_ADDR,
    output logic [31:0] bus_DAT_O,
    input  logic [31:0] bus_DAT_I,
    input  logic        bus_ACK,
    output logic        bus_err,
    output logic        grant
);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_BUSY    = 2'd1;
    localparam logic [1:0]  ST_RELEASE = 2'd2;
    localparam logic [15:0] WD_LAST    = 16'(TIMEOUT - 1);

    logic [1:0]  stb_vec;
    logic [1:0]  we_vec;
    logic [31:0] addr_arr [2];
    logic [31:0] wdat_arr [2];

    assign stb_vec     = {m1_STB, m0_STB};
    assign we_vec      = {m1_WE, m0_WE};
    assign addr_arr[0] = m0_ADDR;
    assign addr_arr[1] = m1_ADDR;
    assign wdat_arr[0] = m0_DAT_I;
    assign wdat_arr[1] = m1_DAT_I;

    logic [1:0]  state_reg;
    logic [15:0] wd_reg;
    logic        grant_reg;
    logic        bus_stb_reg;
    logic        bus_we_reg;
    logic [31:0] bus_addr_reg;
    logic [31:0] bus_dat_reg;
    logic        bus_err_reg;

    logic [1:0]  armed_vec;
    logic [1:0]  ack_vec;
    logic [31:0] rdat_arr [2];

    logic [1:0]  valid;
    logic        req_any;
    logic        sel_next;
    logic        wd_expired;
    logic        resp_fire;
    logic        resp_err;
    logic [31:0] resp_data;

    assign valid   = stb_vec & armed_vec;
    assign req_any = |valid;

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        sel_next = grant_reg;
        if (&valid) begin
            sel_next = ~grant_reg;
        end else if (valid[1]) begin
            sel_next = 1'b1;
        end else if (valid[0]) begin
            sel_next = 1'b0;
        end
    end

    // A slave ACK on the watchdog's last cycle wins: normal completion, no error.
    always_comb begin
        wd_expired = (wd_reg == WD_LAST);
        resp_fire  = (state_reg == ST_BUSY) && (bus_ACK || wd_expired);
        resp_err   = (state_reg == ST_BUSY) && !bus_ACK && wd_expired;
        resp_data  = bus_ACK ? bus_DAT_I : ERR_DATA;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            logic        armed_reg;
            logic        ack_reg;
            logic [31:0] rdat_reg;
            logic        mine;

            assign mine = resp_fire && (grant_reg == 1'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    armed_reg <= 1'b1;
                    ack_reg   <= 1'b0;
                    rdat_reg  <= 32'd0;
                end else begin
                    ack_reg <= mine;
                    if (mine) begin
                        rdat_reg  <= resp_data;
                        armed_reg <= 1'b0;
                    end else if (!stb_vec[gi]) begin
                        armed_reg <= 1'b1;
                    end
                end
            end

            assign armed_vec[gi] = armed_reg;
            assign ack_vec[gi]   = ack_reg;
            assign rdat_arr[gi]  = rdat_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= 1'b1;
            wd_reg       <= 16'd0;
            bus_stb_reg  <= 1'b0;
            bus_we_reg   <= 1'b0;
            bus_addr_reg <= 32'd0;
            bus_dat_reg  <= 32'd0;
            bus_err_reg  <= 1'b0;
        end else begin
            bus_err_reg <= resp_err;
            case (state_reg)
                ST_IDLE: begin
                    if (req_any) begin
                        grant_reg    <= sel_next;
                        bus_we_reg   <= we_vec[sel_next];
                        bus_addr_reg <= addr_arr[sel_next];
                        bus_dat_reg  <= wdat_arr[sel_next];
                        bus_stb_reg  <= 1'b1;
                        wd_reg       <= 16'd0;
                        state_reg    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (resp_fire) begin
                        bus_stb_reg <= 1'b0;
                        state_reg   <= ST_RELEASE;
                    end else if (wd_reg != 16'hFFFF) begin
                        wd_reg <= wd_reg + 16'd1;
                    end
                end
                ST_RELEASE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    bus_stb_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_ACK    = ack_vec[0];
    assign m1_ACK    = ack_vec[1];
    assign m0_DAT_O  = rdat_arr[0];
    assign m1_DAT_O  = rdat_arr[1];
    assign bus_STB   = bus_stb_reg;
    assign bus_WE    = bus_we_reg;
    assign bus_ADDR  = bus_addr_reg;
    assign bus_DAT_O = bus_dat_reg;
    assign bus_err   = bus_err_reg;
    assign grant     = grant_reg;

endmodule
